// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
// Shared definitions for the UART-driven ALU controller: controller state
// type, default opcode width and RX idle timeout, and the ALU opcode values
// understood by the external ALU.
// Optional feature macro used by the controller: RX_TIMEOUT_EN.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    localparam int DEF_OPW           = 6;
    localparam int DEF_TIMEOUT_TICKS = 50000;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// frame_timer
// Inter-byte idle counter for the UART ALU controller. Only compiled when
// RX_TIMEOUT_EN is defined, so the default build carries no timer at all.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   run      in   high on every idle cycle that should be counted; low
//                 clears the count (byte popped, or not waiting mid-frame)
//   expired  out  high on the TICKS-th consecutive run cycle
`ifdef RX_TIMEOUT_EN
module frame_timer #(
    parameter int TICKS = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] count;

    assign expired = run && (count == CW'(TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
// Receives a three-byte frame (A, B, opcode) from a show-ahead RX FIFO,
// presents registered operands to an external combinational ALU, captures
// its result and pushes one result byte into the TX FIFO.
// Optional feature: define RX_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_TICKS idle cycles in GET_B / GET_OP.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   rx_empty    in   RX FIFO empty
//   r_data      in   RX FIFO head byte (valid when rx_empty=0)
//   rd_uart     out  one-cycle RX pop
//   tx_full     in   TX FIFO full
//   w_data      out  result byte for the TX FIFO
//   wr_uart     out  one-cycle TX push
//   alu_a/b     out  registered ALU operands
//   alu_op      out  registered ALU opcode (low OPW bits of third byte)
//   alu_result  in   external ALU result
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT          = 8,
    parameter int OPW           = DEF_OPW,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic [DBIT-1:0] w_data,
    output logic            wr_uart,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [DBIT-1:0] alu_result
);

    if (OPW > DBIT) begin : g_bad_opw
        $error("uart_alu_ctrl: OPW must not exceed DBIT");
    end
    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("uart_alu_ctrl: TIMEOUT_TICKS must be at least 1");
    end

    state_t          state, state_next;
    logic            pop, push, timeout;
    logic [DBIT-1:0] result_reg;

`ifdef RX_TIMEOUT_EN
    logic timer_run;

    // Idle only counts while a frame is partially received.
    assign timer_run = rx_empty && (state == GET_B || state == GET_OP);

    frame_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (timer_run),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        push       = 1'b0;
        unique case (state)
            GET_A: begin
                if (!rx_empty) begin
                    pop        = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (!rx_empty) begin
                    pop        = 1'b1;
                    state_next = GET_OP;
                end else if (timeout) begin
                    state_next = GET_A;
                end
            end
            GET_OP: begin
                if (!rx_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end else if (timeout) begin
                    state_next = GET_A;
                end
            end
            EXEC: begin
                state_next = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    push       = 1'b1;
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    // The pulses are Mealy outputs; gating with reset keeps them low while
    // reset is held even though the reset state GET_A would otherwise pop.
    assign rd_uart = pop && !reset;
    assign wr_uart = push && !reset;
    assign w_data  = result_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result_reg <= '0;
        end else begin
            if (pop && state == GET_A)  alu_a  <= r_data;
            if (pop && state == GET_B)  alu_b  <= r_data;
            if (pop && state == GET_OP) alu_op <= r_data[OPW-1:0];
            if (state == EXEC)          result_reg <= alu_result;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tick_cyc;
    logic rd_seen, wr_seen;
    logic [7:0] wd_seen;
    logic [7:0] rxq [$];

    always #5 clk = ~clk;

    uart_alu_ctrl #(
        .DBIT          (8),
        .OPW           (6),
        .TIMEOUT_TICKS (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // Model of the external ALU, also the reference for random frames.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: present FIFO head, sample Mealy outputs, model the pop.
    task automatic tick();
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
        #1;
        rd_seen  = rd_uart;
        wr_seen  = wr_uart;
        wd_seen  = w_data;
        tick_cyc = cyc;
        if (rd_uart && rxq.size() != 0) void'(rxq.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    // Feeds one frame byte by byte (with idle gaps between bytes), holds
    // tx_full for 'stall' cycles once SEND is reached, and reports the
    // pushed byte, opcode-pop-to-push latency and protocol violations.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input int gap, input int stall,
                              output logic [7:0] got, output int lat, output int viol);
        logic [7:0] fb [3];
        int op_cyc, n;
        fb[0] = a; fb[1] = b; fb[2] = op;
        got = 8'h00; lat = -1; viol = 0; op_cyc = 0;
        tx_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rxq.push_back(fb[k]);
            n = 0;
            do begin tick(); n++; if (wr_seen) viol++; end while (!rd_seen && n < 20);
            if (!rd_seen) begin viol++; return; end
            op_cyc = tick_cyc;
            if (k < 2) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (rd_seen || wr_seen) viol++;
                end
            end
        end
        tick();                                   // EXEC
        if (rd_seen || wr_seen) viol++;
        tx_full = 1'b1;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (rd_seen || wr_seen) viol++;
        end
        tx_full = 1'b0;
        n = 0;
        do begin tick(); n++; if (rd_seen) viol++; end while (!wr_seen && n < 20);
        if (!wr_seen) begin viol++; return; end
        got = wd_seen;
        lat = tick_cyc - op_cyc;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         gap;
        int         stall;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got, a, b, op;
        logic [15:0] rd_mask, wr_mask;
        logic [7:0] wd_at [16];
        int lat, viol, base, stall, bad;
        logic [5:0] ops [8];

        tbl[0] = '{8'h05, 8'h03, 8'h20, 0,  0,  8'h08};
        tbl[1] = '{8'h0F, 8'h01, 8'h22, 0,  0,  8'h0E};
        tbl[2] = '{8'hF0, 8'h3C, 8'h24, 0,  0,  8'h30};
        tbl[3] = '{8'hF0, 8'h0F, 8'h25, 0,  0,  8'hFF};
        tbl[4] = '{8'hAA, 8'hFF, 8'h26, 0,  0,  8'h55};
        tbl[5] = '{8'h81, 8'h02, 8'h03, 0,  0,  8'hE0};
        tbl[6] = '{8'h81, 8'h02, 8'hC2, 0,  0,  8'h20};
        tbl[7] = '{8'h0F, 8'hF0, 8'h27, 0,  0,  8'h00};
        tbl[8] = '{8'h05, 8'h03, 8'h20, 50, 0,  8'h08};
        tbl[9] = '{8'h12, 8'h34, 8'h20, 1,  10, 8'h46};

        ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25;
        ops[4] = 6'h26; ops[5] = 6'h03; ops[6] = 6'h02; ops[7] = 6'h27;

        // Reset state, with a byte waiting so a pop would be visible.
        reset = 1'b1; tx_full = 1'b0; rx_empty = 1'b0; r_data = 8'hA5;
        @(negedge clk); #1;
        check("reset_rd_uart", 32'(rd_uart), 0);
        check("reset_wr_uart", 32'(wr_uart), 0);
        check("reset_alu_a",   32'(alu_a),   0);
        check("reset_alu_b",   32'(alu_b),   0);
        check("reset_alu_op",  32'(alu_op),  0);
        check("reset_w_data",  32'(w_data),  0);
        @(negedge clk);
        reset = 1'b0;
        rxq.delete();

        // Table of single frames: every opcode, RX gaps, TX backpressure.
        foreach (tbl[i]) begin
            send_frame(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].gap, tbl[i].stall, got, lat, viol);
            check($sformatf("vec%0d_w_data", i),  32'(got),  32'(tbl[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat),  32'(2 + tbl[i].stall));
            check($sformatf("vec%0d_protocol", i), 32'(viol), 0);
            check($sformatf("vec%0d_operands", i), {8'h00, alu_a, alu_b, 2'b00, alu_op},
                  {8'h00, tbl[i].a, tbl[i].b, 2'b00, tbl[i].op[5:0]});
        end

        // Back-to-back frames from a preloaded FIFO.
        rxq = '{8'h05, 8'h03, 8'h20, 8'h09, 8'h04, 8'h22};
        tx_full = 1'b0; rd_mask = '0; wr_mask = '0; base = cyc;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (rd_seen) rd_mask[tick_cyc - base] = 1'b1;
            if (wr_seen) begin
                wr_mask[tick_cyc - base] = 1'b1;
                wd_at[tick_cyc - base] = wd_seen;
            end
        end
        check("b2b_rd_cycles", 32'(rd_mask), 32'h00E7);
        check("b2b_wr_cycles", 32'(wr_mask), 32'h0210);
        check("b2b_result0", 32'(wd_at[4]), 32'h08);
        check("b2b_result1", 32'(wd_at[9]), 32'h05);

        // Backpressure in SEND with the next frame already queued.
        rxq = '{8'h12, 8'h34, 8'h20, 8'h01, 8'h01, 8'h20};
        for (int t = 0; t < 4; t++) tick();
        tx_full = 1'b1; bad = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (rd_seen || wr_seen) bad++;
        end
        check("bp_quiet_while_full", 32'(bad), 0);
        tx_full = 1'b0;
        tick();
        check("bp_wr_on_release", 32'(wr_seen), 1);
        check("bp_data_on_release", 32'(wd_seen), 32'h46);
        check("bp_fifo_untouched", 32'(rxq.size()), 3);
        rd_mask = '0; bad = 0; base = cyc;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (rd_seen) rd_mask[tick_cyc - base] = 1'b1;
            if (wr_seen) begin bad++; got = wd_seen; end
        end
        check("bp_next_pops", 32'(rd_mask), 32'h0007);
        check("bp_next_single_wr", 32'(bad), 1);
        check("bp_next_result", 32'(got), 32'h02);

        // Reset while waiting for the opcode byte.
        rxq = '{8'h33, 8'h44};
        for (int t = 0; t < 2; t++) tick();
        rxq.push_back(8'h20);
        rx_empty = 1'b0; r_data = 8'h20; reset = 1'b1;
        #1;
        check("midrst_rd_uart", 32'(rd_uart), 0);
        check("midrst_wr_uart", 32'(wr_uart), 0);
        check("midrst_operands", {8'h00, alu_a, alu_b, 2'b00, alu_op}, 0);
        check("midrst_w_data", 32'(w_data), 0);
        @(negedge clk);
        reset = 1'b0;
        rxq.delete();
        send_frame(8'h07, 8'h02, 8'h22, 0, 0, got, lat, viol);
        check("midrst_fresh_result", 32'(got), 32'h05);
        check("midrst_fresh_latency", 32'(lat), 2);
        check("midrst_fresh_protocol", 32'(viol), 0);

`ifdef RX_TIMEOUT_EN
        // Partial frame abandoned after 100 idle cycles.
        rxq = '{8'h55};
        tick();
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (rd_seen || wr_seen) bad++;
        end
        check("timeout_idle_quiet", 32'(bad), 0);
        send_frame(8'h0F, 8'h01, 8'h22, 0, 0, got, lat, viol);
        check("timeout_fresh_result", 32'(got), 32'h0E);
        check("timeout_fresh_protocol", 32'(viol), 0);
`endif

        // Random frames against the reference ALU.
        for (int i = 0; i < 40; i++) begin
            a     = 8'($urandom);
            b     = 8'($urandom_range(0, 9));
            op    = {2'($urandom), ops[$urandom_range(0, 7)]};
            stall = $urandom_range(0, 3);
            send_frame(a, b, op, $urandom_range(0, 3), stall, got, lat, viol);
            check($sformatf("rnd%0d_result", i),   32'(got),  32'(alu_fn(a, b, op[5:0])));
            check($sformatf("rnd%0d_latency", i),  32'(lat),  32'(2 + stall));
            check($sformatf("rnd%0d_protocol", i), 32'(viol), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
